// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a word-addressed SRAM array.
// One read or write burst at a time; FIXED/INCR/WRAP with byte strobes.
module axi_sram_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IDXW  = $clog2(MEM_WORDS);

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE, RD_DATA, WR_DATA, WR_RESP
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  state_e                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  last_rd_q;

  logic                  rvalid_q, rlast_q, bvalid_q;
  logic [ID_WIDTH-1:0]   rid_q, bid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q, bresp_q;

  function automatic logic [IDXW-1:0] idx(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFF +: IDXW];
  endfunction

  logic                  pick_rd;
  logic [ADDR_WIDTH-1:0] req_addr, req_base;
  logic [7:0]            req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst, req_bt;
  logic                  wrap_ok, req_err;

  assign pick_rd = arvalid & (~awvalid | ~last_rd_q);
  assign arready = (state_q == IDLE) & pick_rd;
  assign awready = (state_q == IDLE) & awvalid & ~pick_rd;
  assign wready  = (state_q == WR_DATA);

  assign req_addr  = pick_rd ? araddr  : awaddr;
  assign req_len   = pick_rd ? arlen   : awlen;
  assign req_size  = pick_rd ? arsize  : awsize;
  assign req_burst = pick_rd ? arburst : awburst;
  assign req_base  = req_addr
                   & ~((ADDR_WIDTH'(1) << req_size) - 1);
  assign wrap_ok   = req_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  // Illegal WRAP lengths still sequence like INCR.
  assign req_bt    = (req_burst == WRAP && !wrap_ok)
                   ? INCR : req_burst;
  assign req_err   = (req_size > 3'(OFF))
                   | (req_burst == WRAP && !wrap_ok);

  logic [ADDR_WIDTH-1:0] step, incr, wmask, addr_d;
  logic                  beat_last, wl_err;

  always_comb begin
    step  = ADDR_WIDTH'(1) << size_q;
    incr  = addr_q + step;
    wmask = ((ADDR_WIDTH'(len_q) + 1) << size_q) - 1;
    case (burst_q)
      FIXED:   addr_d = addr_q;
      WRAP:    addr_d = (addr_q & ~wmask) | (incr & wmask);
      default: addr_d = incr;
    endcase
  end

  assign beat_last = (cnt_q == len_q);
  assign wl_err    = (wlast != beat_last);

  always_ff @(posedge clk) begin
    if (state_q == WR_DATA && wvalid && !err_q && !wl_err) begin
      for (int b = 0; b < LANES; b++) begin
        if (wstrb[b])
          mem_q[idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      last_rd_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arvalid || awvalid) begin
            id_q      <= pick_rd ? arid : awid;
            addr_q    <= req_base;
            len_q     <= req_len;
            size_q    <= req_size;
            burst_q   <= req_bt;
            cnt_q     <= '0;
            err_q     <= req_err;
            last_rd_q <= pick_rd;
          end
          if (pick_rd) begin
            state_q  <= RD_DATA;
            rvalid_q <= 1'b1;
            rdata_q  <= mem_q[idx(req_base)];
            rid_q    <= arid;
            rlast_q  <= (arlen == 8'd0);
            rresp_q  <= req_err ? SLVERR : OKAY;
          end else if (awvalid) begin
            state_q <= WR_DATA;
          end
        end
        RD_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              state_q  <= IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_d;
              rdata_q <= mem_q[idx(addr_d)];
              rlast_q <= (cnt_q + 8'd1 == len_q);
            end
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            err_q <= err_q | wl_err;
            if (beat_last) begin
              state_q  <= WR_RESP;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q | wl_err) ? SLVERR : OKAY;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bvalid = bvalid_q;
  assign bid    = bid_q;
  assign bresp  = bresp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: table of single-beat
// transactions plus hand sequences for bursts, arbitration, reset.
module tb_axi_sram_responder;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk, rst_n;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  axi_sram_responder dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return awready;
      1:       return wready;
      2:       return arready;
      3:       return bvalid;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string nm,
                          output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sig(sel) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got no handshake, want one", nm);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] bt);
    bit ok;
    awid = id; awaddr = a; awlen = len;
    awsize = 3'd2; awburst = bt; awvalid = 1'b1;
    wait_for(0, "aw", ok);
    if (ok) begin @(posedge clk); #1; end
    awvalid = 1'b0;
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] s,
                   input logic l);
    bit ok;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    wait_for(1, "w", ok);
    if (ok) begin @(posedge clk); #1; end
    wvalid = 1'b0;
  endtask

  task automatic b(input logic [3:0] id, input logic [1:0] resp,
                   input string nm);
    bit ok;
    bready = 1'b1;
    wait_for(3, nm, ok);
    if (ok) begin
      chk({nm, " bid"}, 32'(bid), 32'(id));
      chk({nm, " bresp"}, 32'(bresp), 32'(resp));
      @(posedge clk); #1;
    end
    bready = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] bt);
    bit ok;
    arid = id; araddr = a; arlen = len;
    arsize = 3'd2; arburst = bt; arvalid = 1'b1;
    wait_for(2, "ar", ok);
    if (ok) begin @(posedge clk); #1; end
    arvalid = 1'b0;
  endtask

  task automatic r(input logic [31:0] d, input logic l,
                   input logic [1:0] resp, input logic [3:0] id,
                   input int hold, input string nm);
    bit ok;
    rready = 1'b0;
    wait_for(4, nm, ok);
    if (ok) begin
      for (int i = 0; i < hold; i++) begin
        chk({nm, " held rdata"}, rdata, d);
        chk({nm, " held rvalid"}, 32'(rvalid), 32'd1);
        @(negedge clk);
      end
      rready = 1'b1;
      chk({nm, " rdata"}, rdata, d);
      chk({nm, " rlast"}, 32'(rlast), 32'(l));
      chk({nm, " rresp"}, 32'(rresp), 32'(resp));
      chk({nm, " rid"}, 32'(rid), 32'(id));
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    aw(4'd1, a, 8'd0, INCR);
    w(d, s, 1'b1);
    b(4'd1, OKAY, "write1");
  endtask

  task automatic read1(input logic [3:0] id, input logic [31:0] a,
                       input logic [31:0] d, input string nm);
    ar(id, a, 8'd0, INCR);
    r(d, 1'b1, OKAY, id, 0, nm);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;

  vec_t tv[15];

  initial begin
    tv[0]  = '{1'b1, 4'd1, 32'h100,  32'hDEADBEEF, 4'hF};
    tv[1]  = '{1'b0, 4'd2, 32'h100,  32'hDEADBEEF, 4'h0};
    tv[2]  = '{1'b1, 4'd1, 32'h10,   32'h0, 4'hF};
    tv[3]  = '{1'b1, 4'd1, 32'h14,   32'h1, 4'hF};
    tv[4]  = '{1'b1, 4'd1, 32'h18,   32'h2, 4'hF};
    tv[5]  = '{1'b1, 4'd1, 32'h1C,   32'h3, 4'hF};
    tv[6]  = '{1'b1, 4'd1, 32'h200,  32'h11223344, 4'hF};
    tv[7]  = '{1'b1, 4'd1, 32'h200,  32'hAABBCCDD, 4'h5};
    tv[8]  = '{1'b0, 4'd3, 32'h200,  32'h11BB33DD, 4'h0};
    tv[9]  = '{1'b1, 4'd1, 32'h300,  32'h00000000, 4'hF};
    tv[10] = '{1'b1, 4'd1, 32'h300,  32'hFFFFFFFF, 4'hA};
    tv[11] = '{1'b0, 4'd4, 32'h300,  32'hFF00FF00, 4'h0};
    tv[12] = '{1'b0, 4'd5, 32'h4100, 32'hDEADBEEF, 4'h0};
    tv[13] = '{1'b0, 4'd6, 32'h102,  32'hDEADBEEF, 4'h0};
    tv[14] = '{1'b0, 4'd7, 32'h14,   32'h00000001, 4'h0};

    rst_n = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0;
    rready = 1'b0;
    #1 rst_n = 1'b0;

    @(negedge clk);
    chk("rst arready", 32'(arready), 32'd0);
    chk("rst awready", 32'(awready), 32'd0);
    chk("rst wready", 32'(wready), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst bvalid", 32'(bvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst rid", 32'(rid), 32'd0);
    chk("rst rlast", 32'(rlast), 32'd0);
    chk("rst rresp", 32'(rresp), 32'd0);
    chk("rst bid", 32'(bid), 32'd0);
    chk("rst bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tv[i].wr) begin
        aw(tv[i].id, tv[i].addr, 8'd0, INCR);
        w(tv[i].data, tv[i].strb, 1'b1);
        b(tv[i].id, OKAY, $sformatf("tv%0d", i));
      end else begin
        read1(tv[i].id, tv[i].addr, tv[i].data,
              $sformatf("tv%0d", i));
      end
    end

    // INCR with rready 1,0,0,1
    ar(4'd8, 32'h10, 8'd3, INCR);
    r(32'd0, 1'b0, OKAY, 4'd8, 0, "incr b0");
    r(32'd1, 1'b0, OKAY, 4'd8, 2, "incr b1");
    r(32'd2, 1'b0, OKAY, 4'd8, 0, "incr b2");
    r(32'd3, 1'b1, OKAY, 4'd8, 0, "incr b3");
    @(negedge clk);
    chk("incr rvalid after last", 32'(rvalid), 32'd0);
    @(posedge clk); #1;

    ar(4'd9, 32'h1C, 8'd3, WRAP);
    r(32'd3, 1'b0, OKAY, 4'd9, 0, "wrap b0");
    r(32'd0, 1'b0, OKAY, 4'd9, 0, "wrap b1");
    r(32'd1, 1'b0, OKAY, 4'd9, 0, "wrap b2");
    r(32'd2, 1'b1, OKAY, 4'd9, 0, "wrap b3");

    ar(4'd10, 32'h10, 8'd2, WRAP);
    r(32'd0, 1'b0, SLVERR, 4'd10, 0, "badwrap b0");
    r(32'd1, 1'b0, SLVERR, 4'd10, 0, "badwrap b1");
    r(32'd2, 1'b1, SLVERR, 4'd10, 0, "badwrap b2");

    // both channels valid straight out of reset
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    arid = 4'd5; araddr = 32'h100; arlen = 8'd0;
    arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h400; awlen = 8'd0;
    awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
    @(negedge clk);
    chk("arb1 arready", 32'(arready), 32'd1);
    chk("arb1 awready", 32'(awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb busy awready", 32'(awready), 32'd0);
    chk("arb rdata", rdata, 32'hDEADBEEF);
    chk("arb rid", 32'(rid), 32'd5);
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    chk("arb2 awready", 32'(awready), 32'd1);
    chk("arb2 arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    w(32'h55AA55AA, 4'hF, 1'b1);
    b(4'd6, OKAY, "arb b");
    read1(4'd2, 32'h400, 32'h55AA55AA, "arb rd");

    // early wlast on beat 1 of a 3-beat write
    write1(32'h500, 32'hA0A0A0A0, 4'hF);
    write1(32'h504, 32'hB1B1B1B1, 4'hF);
    write1(32'h508, 32'hC2C2C2C2, 4'hF);
    aw(4'd7, 32'h500, 8'd2, INCR);
    w(32'h11111111, 4'h0, 1'b0);
    w(32'h22222222, 4'hF, 1'b1);
    @(negedge clk);
    chk("wlast no early b", 32'(bvalid), 32'd0);
    chk("wlast still wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    w(32'h33333333, 4'hF, 1'b0);
    b(4'd7, SLVERR, "wlast b");
    read1(4'd1, 32'h500, 32'hA0A0A0A0, "wlast m0");
    read1(4'd1, 32'h504, 32'hB1B1B1B1, "wlast m1");
    read1(4'd1, 32'h508, 32'hC2C2C2C2, "wlast m2");

    // reset during beat 2 of a len 7 read
    ar(4'd3, 32'h10, 8'd7, INCR);
    r(32'd0, 1'b0, OKAY, 4'd3, 0, "mid b0");
    r(32'd1, 1'b0, OKAY, 4'd3, 0, "mid b1");
    @(negedge clk);
    chk("mid b2 rvalid", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid async rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid post rvalid", 32'(rvalid), 32'd0);
    chk("mid post bvalid", 32'(bvalid), 32'd0);
    chk("mid post wready", 32'(wready), 32'd0);
    @(posedge clk); #1;
    read1(4'd11, 32'h14, 32'd1, "mid rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
